// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and types for the FIFO read-side packer.
// Holds data/lane defaults, the keep-mask width and the output-load selector.
package fifo_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int LANES_DEF     = 4;
    localparam int KEEP_W        = LANES_DEF;

    typedef enum logic [1:0] {
        LD_NONE,
        LD_FULL,
        LD_FLUSH
    } load_e;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: FIFO read port plus packed-word valid/ready output.
// master = packer side, slave = FIFO/downstream side.
interface fifo_rd_packer_if
    import fifo_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int LANES     = LANES_DEF
);

    logic                       rempty;
    logic [DATA_BITS-1:0]       rdata;
    logic                       rinc;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_BITS*LANES-1:0] out_data;
    logic [LANES-1:0]           out_keep;
    logic                       busy;

    modport master (
        input  rempty, rdata, flush, out_ready,
        output rinc, out_valid, out_data, out_keep, busy
    );

    modport slave (
        output rempty, rdata, flush, out_ready,
        input  rinc, out_valid, out_data, out_keep, busy
    );

endinterface

// File: rtl/fifo_out_stage.sv
// fifo_out_stage: output holding register with valid/ready handshake.
// Ports: clk, rst_n, i_load/i_data/i_keep (new word), i_ready; o_valid/o_data/o_keep, o_free.
module fifo_out_stage
    import fifo_pkg::*;
#(
    parameter int DW = DATA_BITS_DEF * LANES_DEF,
    parameter int KW = KEEP_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic [KW-1:0] i_keep,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [KW-1:0] o_keep,
    output logic          o_free
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [KW-1:0] r_keep;

    // Register may take a new word when empty or being drained this edge.
    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs LANES FWFT FIFO words into one wide word, with flush.
// Ports: rclk, rrst_n, bus (rempty/rdata/rinc/flush/out_valid/out_ready/out_data/out_keep/busy).
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int LANES     = LANES_DEF
) (
    input  logic             rclk,
    input  logic             rrst_n,
    fifo_rd_packer_if.master bus
);

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int OW = DATA_BITS * LANES;
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    logic [CW-1:0]    r_cnt;
    logic [OW-1:0]    r_acc;
    logic             r_flush_pend;

    logic             w_free;
    logic             w_last;
    logic             w_rinc;
    load_e            w_ld;
    logic [OW-1:0]    w_ld_data;
    logic [LANES-1:0] w_ld_keep;
    logic [LANES-1:0] w_part_keep;
    logic             w_out_valid;
    logic [OW-1:0]    w_out_data;
    logic [LANES-1:0] w_out_keep;

    assign w_last = (r_cnt == LAST);

    // The completing pop needs room in the output register; reset masks it.
    assign w_rinc = rrst_n && !bus.rempty && !r_flush_pend
                    && (!w_last || w_free);

    always_comb begin
        w_part_keep = '0;
        for (int i = 0; i < LANES; i++) begin
            w_part_keep[i] = (i < int'(r_cnt));
        end
    end

    // A pop and a pending flush never coincide: the flush blocks pops.
    always_comb begin
        w_ld      = LD_NONE;
        w_ld_data = r_acc;
        w_ld_keep = '0;
        unique case (1'b1)
            (w_rinc && w_last): begin
                w_ld = LD_FULL;
                w_ld_data[OW-1 -: DATA_BITS] = bus.rdata;
                w_ld_keep = '1;
            end
            (r_flush_pend && w_free && r_cnt != '0): begin
                w_ld      = LD_FLUSH;
                w_ld_keep = w_part_keep;
            end
            default: ;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_ld == LD_FULL) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (w_rinc) begin
                r_acc[r_cnt*DATA_BITS +: DATA_BITS] <= bus.rdata;
                r_cnt <= r_cnt + CW'(1);
            end else if (r_flush_pend && w_free) begin
                r_cnt <= '0;
                r_acc <= '0;
            end

            if (r_flush_pend) begin
                if (w_free) begin
                    r_flush_pend <= 1'b0;
                end
            end else if (bus.flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    fifo_out_stage #(
        .DW (OW),
        .KW (LANES)
    ) u_out (
        .clk     (rclk),
        .rst_n   (rrst_n),
        .i_load  (w_ld != LD_NONE),
        .i_data  (w_ld_data),
        .i_keep  (w_ld_keep),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_data  (w_out_data),
        .o_keep  (w_out_keep),
        .o_free  (w_free)
    );

    assign bus.rinc      = w_rinc;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_keep  = w_out_keep;
    assign bus.busy      = (r_cnt != '0) || r_flush_pend;

endmodule
